// File: rtl/layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : layer_sequencer                                                   |
// | Brief  : Sequences one fully-connected layer over a shared MAC datapath:   |
// |          clear, stream N_IN address pairs, drain, write back per neuron.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module layer_sequencer #(
    parameter int N_IN   = 16,
    parameter int N_OUT  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              act_wr,
    output logic [ADDR_W-1:0] out_idx
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_clr   = 3'd1;
    localparam logic [2:0] c_st_issue = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_write = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    localparam logic [ADDR_W-1:0] c_last_i = ADDR_W'(N_IN - 1);
    localparam logic [ADDR_W-1:0] c_last_j = ADDR_W'(N_OUT - 1);
    localparam logic [ADDR_W-1:0] c_one    = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_j;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_acc_en;

    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_i_nxt;
    logic [ADDR_W-1:0] w_j_nxt;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic              w_abort;
    logic              w_mem_rd;

    assign w_abort  = abort && (r_state != c_st_idle);
    assign w_mem_rd = (r_state == c_st_issue);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_i      <= '0;
            r_j      <= '0;
            r_waddr  <= '0;
            r_acc_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_waddr  <= w_waddr_nxt;
            // memory read latency is one cycle, so data arrives the cycle after mem_rd
            r_acc_en <= w_abort ? 1'b0 : w_mem_rd;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_waddr_nxt = r_waddr;
        if (w_abort) begin
            w_state_nxt = c_st_idle;
            w_i_nxt     = '0;
            w_j_nxt     = '0;
            w_waddr_nxt = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        w_state_nxt = c_st_clr;
                        w_j_nxt     = '0;
                        w_waddr_nxt = '0;
                    end
                end
                c_st_clr: begin
                    w_i_nxt     = '0;
                    w_state_nxt = c_st_issue;
                end
                c_st_issue: begin
                    // weight address is a running count, no j*N_IN product needed
                    w_i_nxt     = r_i + c_one;
                    w_waddr_nxt = r_waddr + c_one;
                    if (r_i == c_last_i) begin
                        w_state_nxt = c_st_drain;
                    end
                end
                c_st_drain: begin
                    w_state_nxt = c_st_write;
                end
                c_st_write: begin
                    if (out_ready) begin
                        if (r_j == c_last_j) begin
                            w_state_nxt = c_st_done;
                        end else begin
                            w_j_nxt     = r_j + c_one;
                            w_state_nxt = c_st_clr;
                        end
                    end
                end
                c_st_done: begin
                    w_state_nxt = c_st_idle;
                end
                default: begin
                    w_state_nxt = c_st_idle;
                end
            endcase
        end
    end

    assign busy    = (r_state != c_st_idle);
    assign done    = (r_state == c_st_done);
    assign mem_rd  = w_mem_rd;
    assign in_addr = w_mem_rd ? r_i : '0;
    assign w_addr  = w_mem_rd ? r_waddr : '0;
    assign acc_clr = (r_state == c_st_clr);
    assign acc_en  = r_acc_en;
    assign act_wr  = (r_state == c_st_write);
    assign out_idx = (r_state == c_st_write) ? r_j : '0;

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Sequences one fully-connected neural-network layer over a shared MAC datapath.
- For each output neuron it clears the accumulator, streams N_IN input/weight address pairs to the memories, accumulates the returned products, then hands the result to the activation/writeback stage.
- Sits between the top-level start/ready handshake and the MAC unit plus the input and weight memories.

Parameters:
- N_IN, 16, inputs per neuron (≥1).
- N_OUT, 8, neurons in the layer (≥1).
- ADDR_W, 16, width of the address and index outputs. N_IN*N_OUT must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin layer; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE, no done.
- out_ready  in  1  writeback stage accepts the result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at layer completion.
- mem_rd  out  1  read strobe to the input and weight memories.
- in_addr  out  ADDR_W  input-vector address i.
- w_addr  out  ADDR_W  weight address j*N_IN+i.
- acc_clr  out  1  clear the accumulator.
- acc_en  out  1  accumulate the product of the current memory data.
- act_wr  out  1  result valid for writeback.
- out_idx  out  ADDR_W  neuron index j for writeback.

Behaviour:
- State machine states: IDLE, CLR, ISSUE, DRAIN, WRITE, DONE.
  - State, counter i, counter j and the w_addr running counter are registered.
  - acc_en is a register: it equals mem_rd from the previous cycle, because memory read latency is fixed at 1.
  - All other outputs are decoded combinationally from registered state and counters.
- Reset (async, any time): state IDLE, i=0, j=0, w_addr=0, acc_en=0. Every output is then 0.
- IDLE:
  - start=1 -> CLR, with j=0 and w_addr=0.
  - start=0 -> stay in IDLE.
- CLR:
  - acc_clr=1 for exactly one cycle; i <= 0.
  - -> ISSUE.
- ISSUE:
  - mem_rd=1, in_addr=i, w_addr = running counter.
  - Each cycle: i++ and w_addr++. The weight address is never formed with a multiplier.
  - When i==N_IN-1 -> DRAIN. ISSUE therefore lasts exactly N_IN cycles.
- DRAIN:
  - One cycle; mem_rd=0. acc_en is high here for the last product.
  - -> WRITE.
- WRITE:
  - act_wr=1, out_idx=j. act_wr is held until out_ready=1 in the same cycle; that cycle is the transfer.
  - On transfer, if j==N_OUT-1 -> DONE.
  - On transfer otherwise: j++ -> CLR.
  - out_ready is ignored in every other state.
- DONE:
  - done=1 for one cycle; -> IDLE.
  - busy remains 1 during DONE.
- acc_en is high on exactly the N_IN cycles that follow the ISSUE cycles, i.e. ISSUE cycles 2..N_IN plus DRAIN.
- acc_clr never coincides with acc_en.
- Cycle count with out_ready held at 1:
  - Each neuron takes N_IN+3 cycles (CLR + ISSUE + DRAIN + WRITE).
  - done is asserted N_OUT*(N_IN+3)+1 cycles after the edge at which start is sampled.
  - Each cycle of out_ready=0 during WRITE adds exactly one cycle.
- start while busy is ignored; it does not queue a second layer.
- abort:
  - abort=1 in any non-IDLE state -> IDLE next edge; counters reset; acc_en <= 0; no done pulse.
  - abort has priority over every other transition.
  - abort in IDLE has no effect, even with start=1 in the same cycle.
- Edge sizes:
  - N_IN=1: ISSUE lasts one cycle.
  - N_OUT=1: the first WRITE transfer goes to DONE.
- Counters do not wrap within a legal layer. w_addr reaches at most N_IN*N_OUT-1.

Test Plan:
- Reset mid-ISSUE:
  - Stimulus: N_IN=4, N_OUT=2; rst asserted asynchronously in the third ISSUE cycle of neuron 1.
  - Response: all outputs go to 0 immediately; busy=0; a subsequent start restarts with w_addr=0.
- Nominal layer:
  - Stimulus: N_IN=4, N_OUT=2, out_ready=1, one-cycle start pulse.
  - Response: w_addr sequence 0,1,2,3 then 4,5,6,7; in_addr 0..3 twice; acc_clr pulses twice; acc_en high for 4 cycles per neuron; act_wr with out_idx 0 then 1; done in cycle 15 after start; busy=0 afterwards.
- Backpressure:
  - Stimulus: same layer with out_ready=0 for 3 cycles in neuron 0 WRITE.
  - Response: act_wr and out_idx=0 held steady; done delayed to cycle 18; no extra mem_rd.
- Abort:
  - Stimulus: abort=1 during neuron 1 ISSUE.
  - Response: next cycle IDLE; busy=0; done never pulses; acc_en=0.
- Start while busy:
  - Stimulus: start held at 1 for the whole layer.
  - Response: exactly one layer runs (done pulse count 1); busy=0 for one cycle after DONE; then a second layer begins.
- Minimum size:
  - Stimulus: N_IN=1, N_OUT=1.
  - Response: states CLR, ISSUE, DRAIN, WRITE, DONE; done 5 cycles after start; w_addr=0.
